instr_fetch_unit: RTL

- Consumer end of the program-counter interface.
- Takes each new fetch address (pc_i/pc_valid_i) and issues a single-outstanding read to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words with their PC in a small FIFO and presents them to decode on a valid/ready interface.
- Drives stall_o back to the PC so it holds its value while the unit cannot accept an address; flush_i (any redirect, i.e. PCSEL != 000) discards in-flight and buffered work.

---
 rtl/instr_fetch_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: accepts fetch addresses from the PC, issues one outstanding
// memory read at a time and buffers returned words (with PC/fault) for decode.
module instr_fetch_unit #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic [AW-1:0] pc_i,
  input  logic          pc_valid_i,
  input  logic          flush_i,
  output logic          stall_o,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [AW-1:0] mem_rdata_i,
  output logic          instr_valid_o,
  output logic [AW-1:0] instr_o,
  output logic [AW-1:0] instr_pc_o,
  output logic          instr_fault_o,
  input  logic          instr_ready_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          drop_q, drop_d;

  logic [AW-1:0] fifo_instr_q [DEPTH];
  logic [AW-1:0] fifo_instr_d [DEPTH];
  logic [AW-1:0] fifo_pc_q    [DEPTH];
  logic [AW-1:0] fifo_pc_d    [DEPTH];
  logic          fifo_fault_q [DEPTH];
  logic          fifo_fault_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;

  logic          accept, push, pop, push_fault;
  logic [AW-1:0] push_instr, push_pc;

  assign stall_o       = flush_i | (state_q != IDLE) | (count_q == FULL);
  assign accept        = pc_valid_i & ~stall_o;
  assign pop           = instr_ready_i & (count_q != '0);

  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = fifo_instr_q[rptr_q];
  assign instr_pc_o    = fifo_pc_q[rptr_q];
  assign instr_fault_o = fifo_fault_q[rptr_q];

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    drop_d       = drop_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_fault_d = fifo_fault_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    push         = 1'b0;
    push_instr   = '0;
    push_pc      = '0;
    push_fault   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (pc_i[1:0] == 2'b00) begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_i;
          end else begin
            push       = 1'b1;
            push_pc    = pc_i;
            push_fault = 1'b1;
          end
        end
      end
      REQ: begin
        // Request stays up until granted; a flush is remembered and the response dropped.
        if (flush_i) drop_d = 1'b1;
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          state_d   = (drop_q | flush_i) ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
          if (!flush_i) begin
            push       = 1'b1;
            push_instr = mem_rdata_i;
            push_pc    = mem_addr_q;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        fifo_instr_d[wptr_q] = push_instr;
        fifo_pc_d[wptr_q]    = push_pc;
        fifo_fault_d[wptr_q] = push_fault;
        wptr_d               = wptr_q + PW'(1);
      end
      if (pop) rptr_d = rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      drop_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
        fifo_fault_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      drop_q       <= drop_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_fault_q <= fifo_fault_d;
    end
  end

endmodule
